anton_neopixel_bus_arbiter: RTL and testbench

- Shares the single byte-wide pixel/register bus of the neopixel raw core between two requesters: A (CPU/MSS bridge) and B (pattern/animation engine).
- Round-robin arbitration, one transaction in flight, fixed-latency read capture.
- Optional anti-tearing gate: B writes into the pixel buffer are held off until the core is in its reset/latch window, signalled by pixelsSync.
- Sits between the fabric bus masters and the core, in the busClk domain.

---
 rtl/anton_neopixel_bus_arbiter_pkg.sv | 9 +
 rtl/anton_neopixel_bus_arbiter_if.sv | 22 ++
 rtl/anton_neopixel_bus_arbiter_sync_bit.sv | 16 +
 rtl/anton_neopixel_bus_arbiter.sv | 85 ++++++++
 tb/tb_anton_neopixel_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/anton_neopixel_bus_arbiter_pkg.sv
// anton_neopixel_bus_arbiter_pkg: shared FSM/grant types and the pixel-gate rule for the bus arbiter
package anton_neopixel_bus_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_WRITE, ARB_READ, ARB_CAPTURE} arb_state_t;
    typedef enum logic {GRANT_A, GRANT_B} grant_t;
    // A pixel-buffer write (register-select bit clear) is held off outside the latch window
    function automatic logic pixel_gated(input logic gate, input logic write, input logic reg_sel, input logic sync);
        return gate && write && !reg_sel && !sync;
    endfunction
endpackage

// File: rtl/anton_neopixel_bus_arbiter_if.sv
// anton_neopixel_bus_arbiter_if: requester A/B handshakes plus the core pixel/register bus
//   slave  : arbiter side (takes requests, drives acks/read data and the core strobes)
//   master : requesters and core model side
interface anton_neopixel_bus_arbiter_if #(parameter int ADDR_BITS = 14);
    logic                 aReq, aWrite, aAck;
    logic [ADDR_BITS-1:0] aAddr;
    logic [7:0]           aDataIn, aDataOut;
    logic                 bReq, bWrite, bAck;
    logic [ADDR_BITS-1:0] bAddr;
    logic [7:0]           bDataIn, bDataOut;
    logic [ADDR_BITS-1:0] busAddr;
    logic [7:0]           busDataIn, busDataOut;
    logic                 busWrite, busRead, busy;
    modport slave (
        input  aReq, aWrite, aAddr, aDataIn, bReq, bWrite, bAddr, bDataIn, busDataOut,
        output aAck, aDataOut, bAck, bDataOut, busAddr, busDataIn, busWrite, busRead, busy
    );
    modport master (
        output aReq, aWrite, aAddr, aDataIn, bReq, bWrite, bAddr, bDataIn, busDataOut,
        input  aAck, aDataOut, bAck, bDataOut, busAddr, busDataIn, busWrite, busRead, busy
    );
endinterface

// File: rtl/anton_neopixel_bus_arbiter_sync_bit.sv
// anton_neopixel_bus_arbiter_sync_bit: STAGES-flop synchroniser for a clk7mhz status bit into busClk
//   clk, rst_n (async, active-low), d (asynchronous input), q (synchronised output)
module anton_neopixel_bus_arbiter_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) chain <= '0;
        else chain <= (chain << 1) | STAGES'(d);
    assign q = chain[STAGES-1];
endmodule

// File: rtl/anton_neopixel_bus_arbiter.sv
// anton_neopixel_bus_arbiter: round-robin A/B arbiter for the neopixel core byte bus with pixel anti-tearing gate
//   busClk, busResetn (async, active-low), pixelsSync (async latch-window flag), bus (slave modport:
//   A/B request handshakes, core address/data/strobes, busy)
module anton_neopixel_bus_arbiter
    import anton_neopixel_bus_arbiter_pkg::*;
#(
    parameter int ADDR_BITS     = 14,
    parameter int GATE_B_PIXELS = 1,
    parameter int GATE_A_PIXELS = 0,
    parameter int SYNC_STAGES   = 2
) (
    input logic busClk,
    input logic busResetn,
    input logic pixelsSync,
    anton_neopixel_bus_arbiter_if.slave bus
);
    arb_state_t state;
    grant_t     grant, last_grant;
    logic       sync_pixels, a_ok, b_ok, pick_b, pick_write;

    anton_neopixel_bus_arbiter_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (busClk),
        .rst_n (busResetn),
        .d     (pixelsSync),
        .q     (sync_pixels)
    );

    // A gated requester drops out of eligibility so it never blocks the other one
    always_comb begin
        a_ok       = bus.aReq && !pixel_gated(GATE_A_PIXELS != 0, bus.aWrite, bus.aAddr[ADDR_BITS-1], sync_pixels);
        b_ok       = bus.bReq && !pixel_gated(GATE_B_PIXELS != 0, bus.bWrite, bus.bAddr[ADDR_BITS-1], sync_pixels);
        pick_b     = b_ok && (!a_ok || last_grant == GRANT_A);
        pick_write = pick_b ? bus.bWrite : bus.aWrite;
    end

    // Strobes, acks and busy are registered alongside the state so each tracks its state exactly
    always_ff @(posedge busClk or negedge busResetn) begin
        if (!busResetn) begin
            state         <= ARB_IDLE;
            grant         <= GRANT_A;
            last_grant    <= GRANT_B;
            bus.busAddr   <= '0;
            bus.busDataIn <= '0;
            bus.busWrite  <= 1'b0;
            bus.busRead   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.aAck      <= 1'b0;
            bus.bAck      <= 1'b0;
            bus.aDataOut  <= '0;
            bus.bDataOut  <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (a_ok || b_ok) begin
                    grant         <= pick_b ? GRANT_B : GRANT_A;
                    last_grant    <= pick_b ? GRANT_B : GRANT_A;
                    bus.busAddr   <= pick_b ? bus.bAddr : bus.aAddr;
                    bus.busDataIn <= pick_b ? bus.bDataIn : bus.aDataIn;
                    state         <= pick_write ? ARB_WRITE : ARB_READ;
                    bus.busWrite  <= pick_write;
                    bus.busRead   <= !pick_write;
                    bus.busy      <= 1'b1;
                    bus.aAck      <= pick_write && !pick_b;
                    bus.bAck      <= pick_write && pick_b;
                end
                ARB_READ: begin
                    // The core presents read data while busRead is high; it is taken at the CAPTURE entry edge
                    state       <= ARB_CAPTURE;
                    bus.busRead <= 1'b0;
                    bus.aAck    <= grant == GRANT_A;
                    bus.bAck    <= grant == GRANT_B;
                    if (grant == GRANT_A) bus.aDataOut <= bus.busDataOut;
                    else bus.bDataOut <= bus.busDataOut;
                end
                default: begin
                    state        <= ARB_IDLE;
                    bus.busWrite <= 1'b0;
                    bus.busRead  <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.aAck     <= 1'b0;
                    bus.bAck     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// tb_anton_neopixel_bus_arbiter: scenario tasks plus randomized contention against a transaction-level model
module tb_anton_neopixel_bus_arbiter;
    localparam int SYNC_STAGES = 2;

    logic busClk = 1'b0;
    logic busResetn = 1'b0;
    logic pixelsSync = 1'b0;
    int total = 0;
    int bad = 0;
    int m_last = 1;
    logic [7:0] ref_mem [0:16383];
    logic [7:0] core_mem [0:16383];
    bit core_wr [0:16383];
    logic [7:0] a_hold;

    anton_neopixel_bus_arbiter_if #(.ADDR_BITS(14)) bus ();

    anton_neopixel_bus_arbiter #(
        .ADDR_BITS(14), .GATE_B_PIXELS(1), .GATE_A_PIXELS(0), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .busClk     (busClk),
        .busResetn  (busResetn),
        .pixelsSync (pixelsSync),
        .bus        (bus)
    );

    always #5 busClk = ~busClk;

    function automatic logic [7:0] init_byte(input logic [13:0] a);
        return a[7:0] ^ 8'h1E;
    endfunction

    always @(posedge busClk)
        if (bus.busWrite) begin
            core_mem[bus.busAddr] <= bus.busDataIn;
            core_wr[bus.busAddr]  <= 1'b1;
        end
    assign bus.busDataOut = core_wr[bus.busAddr] ? core_mem[bus.busAddr] : init_byte(bus.busAddr);

    task automatic new_a();
        bus.aWrite  = 1'($urandom % 2);
        bus.aAddr   = {1'($urandom % 2), 13'($urandom % 8)};
        bus.aDataIn = 8'($urandom);
        bus.aReq    = 1'b1;
    endtask

    task automatic new_b();
        bus.bWrite  = 1'($urandom % 2);
        bus.bAddr   = {1'($urandom % 2), 13'($urandom % 8)};
        bus.bDataIn = 8'($urandom);
        bus.bReq    = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge busClk);
        total++;
        if ({bus.busWrite, bus.busRead, bus.busy, bus.aAck, bus.bAck} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {bus.busWrite, bus.busRead, bus.busy, bus.aAck, bus.bAck});
        end
        total++;
        if ({bus.busAddr, bus.busDataIn, bus.aDataOut, bus.bDataOut} !== '0) begin
            bad++; $display("FAIL reset_data addr=%h din=%h aout=%h bout=%h want all 0", bus.busAddr, bus.busDataIn, bus.aDataOut, bus.bDataOut);
        end
        busResetn = 1'b1;
        m_last = 1;
    endtask

    task automatic test_a_write();
        bus.aWrite = 1'b1; bus.aAddr = 14'h0005; bus.aDataIn = 8'hA5; bus.aReq = 1'b1;
        @(negedge busClk);
        total++;
        if ({bus.busWrite, bus.aAck, bus.bAck, bus.busAddr, bus.busDataIn} !== {3'b110, 14'h0005, 8'hA5}) begin
            bad++; $display("FAIL a_write got wr=%b aack=%b back=%b addr=%h din=%h want 1 1 0 0005 a5", bus.busWrite, bus.aAck, bus.bAck, bus.busAddr, bus.busDataIn);
        end
        bus.aReq = 1'b0; ref_mem[14'h0005] = 8'hA5; m_last = 0;
        @(negedge busClk);
        total++;
        if ({bus.busWrite, bus.busy, bus.aAck} !== 3'b000) begin
            bad++; $display("FAIL a_write_after got=%b want=000", {bus.busWrite, bus.busy, bus.aAck});
        end
    endtask

    task automatic test_a_read();
        bus.aWrite = 1'b0; bus.aAddr = 14'h2002; bus.aReq = 1'b1;
        @(negedge busClk);
        total++;
        if ({bus.busRead, bus.busWrite, bus.aAck} !== 3'b100) begin
            bad++; $display("FAIL a_read_strobe got=%b want=100", {bus.busRead, bus.busWrite, bus.aAck});
        end
        @(negedge busClk);
        total++;
        if ({bus.aAck, bus.busRead, bus.aDataOut} !== {2'b10, 8'h1C}) begin
            bad++; $display("FAIL a_read_ack ack=%b rd=%b data=%h want 1 0 1c", bus.aAck, bus.busRead, bus.aDataOut);
        end
        bus.aReq = 1'b0; a_hold = 8'h1C; m_last = 0;
        @(negedge busClk);
        bus.aWrite = 1'b1; bus.aAddr = 14'h0009; bus.aDataIn = 8'h42; bus.aReq = 1'b1;
        @(negedge busClk);
        bus.aReq = 1'b0; ref_mem[14'h0009] = 8'h42;
        @(negedge busClk);
        total++;
        if (bus.aDataOut !== a_hold) begin
            bad++; $display("FAIL a_read_hold got=%h want=%h", bus.aDataOut, a_hold);
        end
    endtask

    task automatic test_b_ungated();
        bus.bWrite = 1'b1; bus.bAddr = 14'h2002; bus.bDataIn = 8'h3C; bus.bReq = 1'b1;
        @(negedge busClk);
        total++;
        if ({bus.bAck, bus.busWrite, bus.busAddr} !== {2'b11, 14'h2002}) begin
            bad++; $display("FAIL b_reg_write ack=%b wr=%b addr=%h want 1 1 2002", bus.bAck, bus.busWrite, bus.busAddr);
        end
        bus.bReq = 1'b0; ref_mem[14'h2002] = 8'h3C; m_last = 1;
        @(negedge busClk);
        bus.bWrite = 1'b0; bus.bAddr = 14'h0003; bus.bReq = 1'b1;
        @(negedge busClk);
        total++;
        if ({bus.busRead, bus.bAck} !== 2'b10) begin
            bad++; $display("FAIL b_pix_read_strobe got=%b want=10", {bus.busRead, bus.bAck});
        end
        @(negedge busClk);
        total++;
        if ({bus.bAck, bus.bDataOut} !== {1'b1, ref_mem[14'h0003]}) begin
            bad++; $display("FAIL b_pix_read ack=%b data=%h want 1 %h", bus.bAck, bus.bDataOut, ref_mem[14'h0003]);
        end
        bus.bReq = 1'b0;
        @(negedge busClk);
        total++;
        if (bus.aDataOut !== a_hold) begin
            bad++; $display("FAIL a_hold_after_b got=%h want=%h", bus.aDataOut, a_hold);
        end
    endtask

    task automatic test_gate_b();
        int d;
        pixelsSync = 1'b0;
        repeat (SYNC_STAGES + 1) @(negedge busClk);
        bus.bWrite = 1'b1; bus.bAddr = 14'h0003; bus.bDataIn = 8'h77; bus.bReq = 1'b1;
        bus.aWrite = 1'b1; bus.aAddr = 14'h2000; bus.aDataIn = 8'h11; bus.aReq = 1'b1;
        @(negedge busClk);
        total++;
        if ({bus.aAck, bus.bAck, bus.busAddr, bus.busDataIn} !== {2'b10, 14'h2000, 8'h11}) begin
            bad++; $display("FAIL gate_a_served aack=%b back=%b addr=%h din=%h want 1 0 2000 11", bus.aAck, bus.bAck, bus.busAddr, bus.busDataIn);
        end
        bus.aReq = 1'b0; ref_mem[14'h2000] = 8'h11; m_last = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge busClk);
            total++;
            if ({bus.bAck, bus.busy} !== 2'b00) begin
                bad++; $display("FAIL gate_b_stall cycle=%0d got=%b want=00", k, {bus.bAck, bus.busy});
            end
        end
        pixelsSync = 1'b1;
        d = 0;
        for (int k = 1; k <= 10 && d == 0; k++) begin
            @(negedge busClk);
            if (bus.bAck) d = k;
        end
        total++;
        if (d < SYNC_STAGES + 1 || d > SYNC_STAGES + 2) begin
            bad++; $display("FAIL gate_b_release delay=%0d want %0d..%0d", d, SYNC_STAGES + 1, SYNC_STAGES + 2);
        end
        total++;
        if ({bus.busAddr, bus.busDataIn} !== {14'h0003, 8'h77}) begin
            bad++; $display("FAIL gate_b_data addr=%h din=%h want 0003 77", bus.busAddr, bus.busDataIn);
        end
        bus.bReq = 1'b0; ref_mem[14'h0003] = 8'h77; m_last = 1;
        @(negedge busClk);
    endtask

    task automatic test_contention();
        logic win_b, w;
        logic [13:0] ad;
        logic [7:0] dt, got;
        int lat;
        new_a(); new_b();
        for (int t = 0; t < 40; t++) begin
            win_b = (m_last == 0);
            w  = win_b ? bus.bWrite : bus.aWrite;
            ad = win_b ? bus.bAddr : bus.aAddr;
            dt = win_b ? bus.bDataIn : bus.aDataIn;
            lat = w ? 1 : 2;
            for (int k = 1; k <= lat; k++) begin
                @(negedge busClk);
                total++;
                if ((bus.aAck && bus.bAck) || (bus.busWrite && bus.busRead) || (k < lat && (bus.aAck || bus.bAck))) begin
                    bad++; $display("FAIL contention_overlap t=%0d k=%0d aack=%b back=%b wr=%b rd=%b", t, k, bus.aAck, bus.bAck, bus.busWrite, bus.busRead);
                end
            end
            total++;
            if ({bus.aAck, bus.bAck} !== (win_b ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL contention_grant t=%0d got=%b want=%b", t, {bus.aAck, bus.bAck}, win_b ? 2'b01 : 2'b10);
            end
            got = win_b ? bus.bDataOut : bus.aDataOut;
            total++;
            if (w && {bus.busAddr, bus.busDataIn} !== {ad, dt}) begin
                bad++; $display("FAIL contention_write t=%0d addr=%h din=%h want %h %h", t, bus.busAddr, bus.busDataIn, ad, dt);
            end else if (!w && got !== ref_mem[ad]) begin
                bad++; $display("FAIL contention_read t=%0d addr=%h got=%h want=%h", t, ad, got, ref_mem[ad]);
            end
            if (w) ref_mem[ad] = dt;
            else if (!win_b) a_hold = ref_mem[ad];
            m_last = win_b ? 1 : 0;
            if (win_b) new_b(); else new_a();
            @(negedge busClk);
            total++;
            if ({bus.busy, bus.aAck, bus.bAck} !== 3'b000) begin
                bad++; $display("FAIL contention_idle t=%0d got=%b want=000", t, {bus.busy, bus.aAck, bus.bAck});
            end
        end
        bus.aReq = 1'b0; bus.bReq = 1'b0;
        repeat (3) @(negedge busClk);
        total++;
        if (bus.aDataOut !== a_hold) begin
            bad++; $display("FAIL contention_a_hold got=%h want=%h", bus.aDataOut, a_hold);
        end
    endtask

    task automatic test_reset_mid_read();
        bus.aWrite = 1'b0; bus.aAddr = 14'h2002; bus.aReq = 1'b1;
        @(negedge busClk);
        total++;
        if (bus.busRead !== 1'b1) begin
            bad++; $display("FAIL midrst_read got=%b want=1", bus.busRead);
        end
        #2 busResetn = 1'b0;
        #1;
        total++;
        if ({bus.busRead, bus.aAck, bus.busy, bus.aDataOut} !== 11'b0) begin
            bad++; $display("FAIL midrst_async rd=%b ack=%b busy=%b aout=%h want 0 0 0 00", bus.busRead, bus.aAck, bus.busy, bus.aDataOut);
        end
        bus.aReq = 1'b0;
        @(negedge busClk);
        total++;
        if ({bus.aAck, bus.bAck, bus.busRead} !== 3'b000) begin
            bad++; $display("FAIL midrst_no_ack got=%b want=000", {bus.aAck, bus.bAck, bus.busRead});
        end
        busResetn = 1'b1; m_last = 1;
        bus.aWrite = 1'b0; bus.aAddr = 14'h2002; bus.aReq = 1'b1;
        bus.bWrite = 1'b0; bus.bAddr = 14'h0005; bus.bReq = 1'b1;
        repeat (2) @(negedge busClk);
        total++;
        if ({bus.aAck, bus.bAck, bus.aDataOut} !== {2'b10, ref_mem[14'h2002]}) begin
            bad++; $display("FAIL midrst_tie_a aack=%b back=%b data=%h want 1 0 %h", bus.aAck, bus.bAck, bus.aDataOut, ref_mem[14'h2002]);
        end
        bus.aReq = 1'b0;
        repeat (3) @(negedge busClk);
        total++;
        if ({bus.bAck, bus.bDataOut} !== {1'b1, ref_mem[14'h0005]}) begin
            bad++; $display("FAIL midrst_then_b ack=%b data=%h want 1 %h", bus.bAck, bus.bDataOut, ref_mem[14'h0005]);
        end
        bus.bReq = 1'b0;
        @(negedge busClk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_byte(14'(i));
        bus.aReq = 1'b0; bus.aWrite = 1'b0; bus.aAddr = '0; bus.aDataIn = '0;
        bus.bReq = 1'b0; bus.bWrite = 1'b0; bus.bAddr = '0; bus.bDataIn = '0;
        a_hold = 8'h00;
        test_reset();
        test_a_write();
        test_a_read();
        test_b_ungated();
        test_gate_b();
        test_contention();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
